// File: rtl/cache_pkg.sv
// Shared cache geometry, address field positions, tag-line layout and cache_fsm state encodings.
// Latency: none; this file holds only constants, types and a helper.
// Backpressure: not applicable.
package cache_pkg;

    localparam int ADDR_W      = 16;
    localparam int BLOCKSIZE_W = 5;
    localparam int INDEX_W     = 3;
    localparam int TAG_W       = ADDR_W - INDEX_W - BLOCKSIZE_W;
    localparam int NUM_LINES   = 1 << INDEX_W;
    localparam int BLK_ADDR_W  = ADDR_W - BLOCKSIZE_W;

    localparam int OFFSET_LSB  = 0;
    localparam int OFFSET_MSB  = BLOCKSIZE_W - 1;
    localparam int INDEX_LSB   = BLOCKSIZE_W;
    localparam int INDEX_MSB   = BLOCKSIZE_W + INDEX_W - 1;
    localparam int TAG_LSB     = BLOCKSIZE_W + INDEX_W;
    localparam int TAG_MSB     = ADDR_W - 1;

    // One tag-store entry.
    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } line_t;

    // State encodings used by the downstream cache_fsm.
    typedef enum logic [2:0] {
        FSM_IDLE      = 3'd0,
        FSM_COMPARE   = 3'd1,
        FSM_WRITEBACK = 3'd2,
        FSM_ALLOCATE  = 3'd3,
        FSM_WAIT_MEM  = 3'd4,
        FSM_DONE      = 3'd5
    } fsm_state_t;

    // Block address (tag and index) formed from a tag and an index.
    function automatic logic [BLK_ADDR_W-1:0] blk_addr(input logic [TAG_W-1:0] tag,
                                                       input logic [INDEX_W-1:0] index);
        return {tag, index};
    endfunction

endpackage

// File: rtl/cache_tag_ctrl_if.sv
// Groups the CPU request, FSM handshake and SDRAM block-address signals of the tag controller.
// Latency: wires only.
// Backpressure: the busy output tells the requester that further cs edges are dropped.
interface cache_tag_ctrl_if;
    import cache_pkg::*;

    logic                  cs;
    logic                  wr_rd_cpu;
    logic [ADDR_W-1:0]     addr_cpu;
    logic                  rdy;
    logic                  valid_set;
    logic                  dirty_set;
    logic                  hit;
    logic                  wr_rd_cpu_q;
    logic                  cs_sampled_dly;
    logic                  dirty_line;
    logic                  busy;
    logic [BLK_ADDR_W-1:0] victim_addr;
    logic [BLK_ADDR_W-1:0] fill_addr;

    modport master (
        output cs, wr_rd_cpu, addr_cpu, rdy, valid_set, dirty_set,
        input  hit, wr_rd_cpu_q, cs_sampled_dly, dirty_line, busy, victim_addr, fill_addr
    );

    modport slave (
        input  cs, wr_rd_cpu, addr_cpu, rdy, valid_set, dirty_set,
        output hit, wr_rd_cpu_q, cs_sampled_dly, dirty_line, busy, victim_addr, fill_addr
    );

endinterface

// File: rtl/cache_tag_array.sv
// Direct-mapped tag store of {V, D, tag}: combinational read, V/tag and D write enables.
// Latency: read 0 cycles; writes visible after the clock edge.
// Backpressure: none; every write is accepted.
module cache_tag_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               vt_we,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               d_we,
    input  logic               d_val
);

    line_t lines [NUM_LINES];

    assign rd_valid = lines[rd_index].valid;
    assign rd_dirty = lines[rd_index].dirty;
    assign rd_tag   = lines[rd_index].tag;

    // Clear on reset; an install loads the new tag clean unless a dirty write lands with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines[i] <= '0;
            end
        end else if (vt_we) begin
            lines[wr_index].valid <= 1'b1;
            lines[wr_index].tag   <= wr_tag;
            lines[wr_index].dirty <= d_we & d_val;
        end else if (d_we) begin
            lines[wr_index].dirty <= d_val;
        end
    end

endmodule

// File: rtl/cache_tag_ctrl.sv
// Samples CPU requests on cs rising edge, looks up the tag store and feeds hit/dirty to cache_fsm.
// Latency: accept at E0, lookup results after E1, cs_sampled_dly pulse in the E2-E3 cycle.
// Backpressure: cs edges seen while busy are dropped; busy clears the edge after rdy.
module cache_tag_ctrl
    import cache_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    cache_tag_ctrl_if.slave bus
);

    logic                  cs_prev;
    logic                  busy_q;
    logic                  lookup_pend;
    logic                  pulse_pend;
    logic                  pulse_q;
    logic [TAG_W-1:0]      tag_q;
    logic [INDEX_W-1:0]    index_q;
    logic                  wr_q;
    logic                  hit_q;
    logic                  dirty_q;
    logic [BLK_ADDR_W-1:0] victim_q;
    logic [BLK_ADDR_W-1:0] fill_q;

    logic                  accept;
    logic                  line_hit;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic                  unused_offset;

    // Offset bits select a byte within the block and play no part in tag handling.
    assign unused_offset = ^bus.addr_cpu[OFFSET_MSB:OFFSET_LSB];

    assign accept   = bus.cs & ~cs_prev & ~busy_q;
    assign line_hit = rd_valid && (rd_tag == tag_q);

    // Dirty marking is only legal for writes; the FSM also pulses dirty on read hits.
    cache_tag_array u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (index_q),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .wr_index (index_q),
        .vt_we    (busy_q & bus.valid_set),
        .wr_tag   (tag_q),
        .d_we     (busy_q & bus.dirty_set & wr_q),
        .d_val    (1'b1)
    );

    // Edge detect, request latch, busy tracking and the two-stage delay to the FSM pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_prev     <= 1'b0;
            busy_q      <= 1'b0;
            lookup_pend <= 1'b0;
            pulse_pend  <= 1'b0;
            pulse_q     <= 1'b0;
            tag_q       <= '0;
            index_q     <= '0;
            wr_q        <= 1'b0;
        end else begin
            cs_prev     <= bus.cs;
            lookup_pend <= accept;
            pulse_pend  <= lookup_pend;
            pulse_q     <= pulse_pend;
            if (accept) begin
                busy_q  <= 1'b1;
                tag_q   <= bus.addr_cpu[TAG_MSB:TAG_LSB];
                index_q <= bus.addr_cpu[INDEX_MSB:INDEX_LSB];
                wr_q    <= bus.wr_rd_cpu;
            end else if (busy_q && bus.rdy) begin
                busy_q  <= 1'b0;
            end
        end
    end

    // hit/dirty track the array while busy; block addresses are frozen at lookup so
    // writeback addressing survives the tag overwrite from valid_set.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q    <= 1'b0;
            dirty_q  <= 1'b0;
            victim_q <= '0;
            fill_q   <= '0;
        end else begin
            if (busy_q) begin
                hit_q   <= line_hit;
                dirty_q <= rd_dirty;
            end
            if (lookup_pend) begin
                victim_q <= blk_addr(rd_tag, index_q);
                fill_q   <= blk_addr(tag_q, index_q);
            end
        end
    end

    assign bus.hit            = hit_q;
    assign bus.wr_rd_cpu_q    = wr_q;
    assign bus.cs_sampled_dly = pulse_q;
    assign bus.dirty_line     = dirty_q;
    assign bus.busy           = busy_q;
    assign bus.victim_addr    = victim_q;
    assign bus.fill_addr      = fill_q;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Scoreboard bench for cache_tag_ctrl: requests push expected lookups, a monitor checks each FSM pulse.
// Latency: directed sequences with fixed cycle timing per request.
// Backpressure: exercises dropped edges while busy and cs held high across release.
module tb_cache_tag_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_tag_ctrl_if bus();

    cache_tag_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic                  hit;
        logic                  dirty;
        logic                  wr;
        logic [BLK_ADDR_W-1:0] victim;
        logic [BLK_ADDR_W-1:0] fill;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   pulse_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor: every FSM request pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.cs_sampled_dly === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("hit",         32'(bus.hit),         32'(e.hit));
                chk("dirty_line",  32'(bus.dirty_line),  32'(e.dirty));
                chk("wr_rd_cpu_q", 32'(bus.wr_rd_cpu_q), 32'(e.wr));
                chk("victim_addr", 32'(bus.victim_addr), 32'(e.victim));
                chk("fill_addr",   32'(bus.fill_addr),   32'(e.fill));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full request: accept, wait for the pulse, optional valid/dirty write, release.
    task automatic request(input logic [ADDR_W-1:0] a, input logic wr,
                           input logic eh, input logic ed,
                           input logic [BLK_ADDR_W-1:0] ev, input logic [BLK_ADDR_W-1:0] ef,
                           input logic vs, input logic ds);
        exp_q.push_back('{eh, ed, wr, ev, ef});
        bus.cs        = 1'b1;
        bus.wr_rd_cpu = wr;
        bus.addr_cpu  = a;
        tick();                                  // E0
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        bus.cs = 1'b0;
        tick();                                  // E1
        tick();                                  // E2
        tick();                                  // E3
        bus.valid_set = vs;
        bus.dirty_set = ds;
        tick();                                  // array write
        bus.valid_set = 1'b0;
        bus.dirty_set = 1'b0;
        bus.rdy       = 1'b1;
        tick();                                  // release
        bus.rdy = 1'b0;
        chk("busy_after_rdy", 32'(bus.busy), 32'd0);
        tick();
    endtask

    initial begin
        int p0;
        rst           = 1'b1;
        bus.cs        = 1'b0;
        bus.wr_rd_cpu = 1'b0;
        bus.addr_cpu  = '0;
        bus.rdy       = 1'b0;
        bus.valid_set = 1'b0;
        bus.dirty_set = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 32'({bus.hit, bus.wr_rd_cpu_q, bus.cs_sampled_dly, bus.dirty_line,
                                  bus.busy, bus.victim_addr, bus.fill_addr}), 32'd0);
        rst = 1'b0;
        tick();

        // Cold miss, then install the line.
        request(16'h1234, 1'b0, 1'b0, 1'b0, 11'h001, 11'h091, 1'b1, 1'b0);
        chk("hit_after_install", 32'(bus.hit), 32'd1);

        // Same tag and index, different offset.
        request(16'h1220, 1'b0, 1'b1, 1'b0, 11'h091, 11'h091, 1'b0, 1'b0);

        // Write hit marks the line dirty.
        request(16'h1220, 1'b1, 1'b1, 1'b0, 11'h091, 11'h091, 1'b0, 1'b1);
        chk("dirty_after_write", 32'(bus.dirty_line), 32'd1);

        // Dirty conflict miss; victim address must survive the install.
        request(16'h5620, 1'b0, 1'b0, 1'b1, 11'h091, 11'h2B1, 1'b1, 1'b0);
        chk("victim_held",        32'(bus.victim_addr), 32'h091);
        chk("hit_after_refill",   32'(bus.hit),         32'd1);
        chk("clean_after_refill", 32'(bus.dirty_line),  32'd0);

        // Read hit with dirty pulse must leave D clear.
        request(16'h5620, 1'b0, 1'b1, 1'b0, 11'h2B1, 11'h2B1, 1'b0, 1'b1);
        chk("read_dirty_ignored", 32'(bus.dirty_line), 32'd0);
        request(16'h7820, 1'b0, 1'b0, 1'b0, 11'h2B1, 11'h3C1, 1'b0, 1'b0);

        // Write miss: install and dirty in the same cycle.
        request(16'h7820, 1'b1, 1'b0, 1'b0, 11'h2B1, 11'h3C1, 1'b1, 1'b1);
        chk("install_dirty", 32'(bus.dirty_line), 32'd1);
        chk("install_hit",   32'(bus.hit),        32'd1);

        // rdy while idle is ignored.
        bus.rdy = 1'b1;
        tick();
        bus.rdy = 1'b0;
        chk("rdy_idle", 32'(bus.busy), 32'd0);
        tick();

        // cs re-edge while busy and cs held through release: one pulse only.
        p0 = pulse_cnt;
        exp_q.push_back('{1'b0, 1'b1, 1'b0, 11'h3C1, 11'h091});
        bus.cs        = 1'b1;
        bus.wr_rd_cpu = 1'b0;
        bus.addr_cpu  = 16'h1234;
        tick();                                  // E0
        bus.cs = 1'b0;
        tick();
        bus.cs = 1'b1;
        tick();                                  // dropped edge
        tick();
        tick();
        bus.rdy = 1'b1;
        tick();
        bus.rdy = 1'b0;
        repeat (4) tick();
        chk("single_pulse", 32'(pulse_cnt - p0), 32'd1);
        chk("busy_cs_held", 32'(bus.busy), 32'd0);
        bus.cs = 1'b0;
        tick();

        // Reset at E1: no pulse, busy cleared, array wiped.
        p0 = pulse_cnt;
        bus.cs        = 1'b1;
        bus.wr_rd_cpu = 1'b0;
        bus.addr_cpu  = 16'h7820;
        tick();                                  // E0
        bus.cs = 1'b0;
        rst    = 1'b1;
        tick();                                  // E1 in reset
        rst = 1'b0;
        repeat (4) tick();
        chk("no_pulse_after_rst", 32'(pulse_cnt - p0), 32'd0);
        chk("busy_after_rst",     32'(bus.busy),        32'd0);
        request(16'h7820, 1'b0, 1'b0, 1'b0, 11'h001, 11'h3C1, 1'b0, 1'b0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_tag_ctrl.md
# cache_tag_ctrl

Front-end request sampler and tag store for the direct-mapped cache. Captures a CPU request on a rising edge of chip select, looks up tag/valid/dirty for the indexed line, and presents `hit`, `wr_rd_cpu_q`, `cs_sampled_dly` and `dirty_line` to `cache_fsm`, the cache controller FSM downstream. Takes the FSM's `valid`/`dirty`/`rdy` outputs back to update line state and release the request. Supplies the victim and fill block addresses for the SDRAM side.

## Interface
- `ADDR_W`, 16, CPU byte address width
- `BLOCKSIZE_W`, 5, offset bits per line (32-byte block)
- `INDEX_W`, 3, index bits (8 lines); tag width TAG_W = ADDR_W-INDEX_W-BLOCKSIZE_W (8)
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `cs` in 1: CPU chip select (level)
- `wr_rd_cpu` in 1: 1 = write, 0 = read
- `addr_cpu` in ADDR_W: CPU address; tag=[15:8], index=[7:5], offset=[4:0]
- `rdy` in 1: from FSM; transaction complete
- `valid_set` in 1: from FSM `valid`; install latched tag, V=1, D=0
- `dirty_set` in 1: from FSM `dirty`; set D of latched line
- `hit` out 1: latched tag matches stored tag and V=1
- `wr_rd_cpu_q` out 1: latched direction
- `cs_sampled_dly` out 1: one-cycle request pulse to FSM
- `dirty_line` out 1: D of latched line (FSM `dirty_input`)
- `busy` out 1: request in flight
- `victim_addr` out ADDR_W-BLOCKSIZE_W: {stored tag, index} for writeback
- `fill_addr` out ADDR_W-BLOCKSIZE_W: {latched tag, index} for fill

## Operation
- Reset: all V/D/tag bits 0; every output 0; `cs` edge detector previous-value cleared to 0.
- Accept: `cs`=1 with previous `cs`=0 and `busy`=0 → latch `addr_cpu`, `wr_rd_cpu`; `busy`←1. Edges while `busy`=1 are dropped, not queued. A `cs` held high through completion does not retrigger.
- Lookup: cycle after accept, register `hit`, `dirty_line`, `victim_addr` from array; `fill_addr` from latched address.
- `hit` and `dirty_line` re-evaluate every cycle from the latched index/tag while `busy`=1, reflecting array updates one cycle later.
- `victim_addr` is frozen at lookup and held until release, so writeback addressing is stable after `valid_set` overwrites the tag.
- `valid_set`: line[index] ← {latched tag, V=1, D=0}.
- `dirty_set`: honoured only when `wr_rd_cpu_q`=1 (the FSM also pulses `dirty` on read hits, which must not mark lines dirty).
- Both in the same cycle: tag/V from `valid_set`, D=1 if `dirty_set` is honoured.
- Release: `rdy`=1 while `busy` → `busy`←0 next edge. Outputs hold their last values until the next lookup.
- `rdy` with `busy`=0 is ignored.
- `rst` mid-request: `busy`, a pending `cs_sampled_dly` and the array are all cleared; the FSM restarts from its own reset.

## Timing
- E0: edge at which an accept is seen; latches the request; `busy`=1 after E0.
- E1: `hit`/`dirty_line`/`victim_addr`/`fill_addr` valid after E1.
- E2: `cs_sampled_dly`=1 for exactly the E2–E3 cycle, so that `hit` is already stable when the FSM samples it in IDLE.
- Array write at edge with `valid_set`/`dirty_set` high; `hit`/`dirty_line` updated at the following edge.
- Minimum request-to-request spacing: `rdy` edge + 1 cycle before the next `cs` edge can be accepted.

## Structure
- Shared package `cache_pkg`: ADDR_W, BLOCKSIZE_W, INDEX_W, TAG_W, and tag/index/offset field LSB/MSB constants; `cache_fsm` state encodings also live there.
- Sub-module `cache_tag_array`: 2^INDEX_W entries of {V, D, tag}. One combinational read port, one write port with separate V/tag and D enables, synchronous clear on `rst`.

## Test plan
- Reset, then read at 0x1234 → `cs_sampled_dly` high only in E2 cycle, `hit`=0, `dirty_line`=0, `fill_addr`=0x091, `busy`=1 until `rdy`.
- `valid_set` on 0x1234, `rdy`, then read 0x1220 → `hit`=1 (tag 0x12, index 1).
- Write 0x1220 hit with `dirty_set`, release, then read 0x5620 → `hit`=0, `dirty_line`=1, `victim_addr`=0x091, `fill_addr`=0x2B1; `victim_addr` unchanged after `valid_set`.
- Read hit with `dirty_set` pulsed → D stays 0; a following request to a different tag gives `dirty_line`=0.
- `cs` held high across `rdy`, plus a second `cs` edge while busy → exactly one `cs_sampled_dly` pulse total.
- `rst` asserted at E1 → no `cs_sampled_dly` pulse, `busy`=0, a prior valid line now misses.
